// File: rtl/fpadd_share_arb.sv
// Two-port front end that time-shares one fixed-latency pipelined FP adder.
// Round-robin issue, owner tag tracking through the adder, per-port credited response FIFOs.
module fpadd_share_arb #(
    parameter int LAT       = 3,
    parameter int RSP_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        add_valid,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_res,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_res,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_res,
    output logic        busy
);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(RSP_DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(RSP_DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(RSP_DEPTH - 1);

    logic [1:0]  req_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] req_a [2];
    logic [31:0] req_b [2];
    logic [1:0]  elig;
    logic [1:0]  grant;
    logic [1:0]  pop;
    logic [1:0]  cap;
    logic [1:0]  rsp_valid_w;
    logic [1:0]  port_busy;
    logic [31:0] head [2];

    logic           last_reg;
    logic           add_valid_reg;
    logic           issue_id_reg;
    logic [31:0]    add_a_reg;
    logic [31:0]    add_b_reg;
    logic [LAT-1:0] tag_valid_reg;
    logic [LAT-1:0] tag_id_reg;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};
    assign req_a[0]  = req0_a;
    assign req_a[1]  = req1_a;
    assign req_b[0]  = req0_b;
    assign req_b[1]  = req1_b;

    // Grants are forced low while reset is asserted so every output reads 0.
    always_comb begin
        grant = 2'b00;
        if (rst_n) begin
            grant[0] = elig[0] && (!elig[1] || last_reg);
            grant[1] = elig[1] && (!elig[0] || !last_reg);
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // Issue register feeds tag stage 0, so stage LAT-1 lines up with add_res.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg      <= 1'b1;
            add_valid_reg <= 1'b0;
            issue_id_reg  <= 1'b0;
            add_a_reg     <= '0;
            add_b_reg     <= '0;
            tag_valid_reg <= '0;
            tag_id_reg    <= '0;
        end else begin
            add_valid_reg <= |grant;
            issue_id_reg  <= grant[1];
            if (|grant) begin
                last_reg  <= grant[1];
                add_a_reg <= grant[1] ? req_a[1] : req_a[0];
                add_b_reg <= grant[1] ? req_b[1] : req_b[0];
            end
            for (int i = LAT - 1; i > 0; i--) begin
                tag_valid_reg[i] <= tag_valid_reg[i-1];
                tag_id_reg[i]    <= tag_id_reg[i-1];
            end
            tag_valid_reg[0] <= add_valid_reg;
            tag_id_reg[0]    <= issue_id_reg;
        end
    end

    assign add_valid = add_valid_reg;
    assign add_a     = add_a_reg;
    assign add_b     = add_b_reg;

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [CW-1:0] out_reg;
        logic [CW-1:0] cnt_reg;
        logic [PW-1:0] wptr_reg;
        logic [PW-1:0] rptr_reg;
        logic [31:0]   mem [RSP_DEPTH];

        // Credit: in-flight plus queued results must leave room in the FIFO.
        assign elig[gi] = req_valid[gi] &&
                          (({1'b0, out_reg} + {1'b0, cnt_reg}) < DEPTH_W);
        assign rsp_valid_w[gi] = (cnt_reg != '0);
        assign pop[gi]         = rsp_valid_w[gi] && rsp_ready[gi];
        assign cap[gi]         = tag_valid_reg[LAT-1] && (tag_id_reg[LAT-1] == 1'(gi));
        assign head[gi]        = mem[rptr_reg];
        assign port_busy[gi]   = (out_reg != '0) || (cnt_reg != '0);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_reg  <= '0;
                cnt_reg  <= '0;
                wptr_reg <= '0;
                rptr_reg <= '0;
            end else begin
                out_reg <= out_reg + CW'(grant[gi]) - CW'(cap[gi]);
                cnt_reg <= cnt_reg + CW'(cap[gi]) - CW'(pop[gi]);
                if (cap[gi]) begin
                    wptr_reg <= (wptr_reg == PTR_LAST) ? '0 : wptr_reg + 1'b1;
                end
                if (pop[gi]) begin
                    rptr_reg <= (rptr_reg == PTR_LAST) ? '0 : rptr_reg + 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (cap[gi]) begin
                mem[wptr_reg] <= add_res;
            end
        end

        always @(posedge clk) begin
            if (rst_n) begin
                assert (!(cap[gi] && (cnt_reg == FULL_CNT) && !pop[gi]));
            end
        end
    end

    assign rsp0_valid = rsp_valid_w[0];
    assign rsp1_valid = rsp_valid_w[1];
    assign rsp0_res   = rsp_valid_w[0] ? head[0] : '0;
    assign rsp1_res   = rsp_valid_w[1] ? head[1] : '0;
    assign busy       = |port_busy;

endmodule
